// File: rtl/siren_phase_meter_if.sv
// Signal bundle between the siren/divider square-wave pair and its phase meter.
// The master drives the complementary pair and observes the measurement;
// the slave (the meter) samples the pair and reports.
interface siren_phase_meter_if #(
  parameter int CNT_W = 27
);
  logic             sig_a;
  logic             sig_b;
  logic [CNT_W-1:0] half_period;
  logic             level;
  logic             meas_valid;
  logic             timeout;
  logic             comp_err;

  modport master (
    output sig_a, sig_b,
    input  half_period, level, meas_valid, timeout, comp_err
  );

  modport slave (
    input  sig_a, sig_b,
    output half_period, level, meas_valid, timeout, comp_err
  );
endinterface

// File: rtl/siren_phase_meter.sv
// Receive-side monitor for the complementary slow square-wave pair.
// Synchronizes sig_a/sig_b, measures every half-period of sig_a in clk
// cycles, strobes each result, flags loss of toggling and flags the pair
// failing to stay complementary.
module siren_phase_meter #(
  parameter int CNT_W   = 27,
  parameter int TIMEOUT = 125000000,
  parameter int GLITCH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  siren_phase_meter_if.slave  mon_if
);

  localparam int MIS_W = $clog2(GLITCH + 2);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MIS_W-1:0] GLITCH_C  = MIS_W'(GLITCH);

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } state_e;

  // Synchronizer and edge-history registers
  logic sa1_q, sa2_q, sb1_q, sb2_q, sa_prev_q;

  // Measurement FSM state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] half_period_q, half_period_d;
  logic             level_q, level_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;

  // Complement checker state
  logic [MIS_W-1:0] mis_cnt_q, mis_cnt_d;
  logic             comp_err_q, comp_err_d;

  logic sa_edge;
  logic pair_eq;

  // Two-flop synchronizers for both inputs; sa_prev_q keeps last synced sig_a.
  // sig_b resets high so the reset state is already a valid complementary pair.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      sa1_q     <= 1'b0;
      sa2_q     <= 1'b0;
      sb1_q     <= 1'b1;
      sb2_q     <= 1'b1;
      sa_prev_q <= 1'b0;
    end else begin
      sa1_q     <= mon_if.sig_a;
      sa2_q     <= sa1_q;
      sb1_q     <= mon_if.sig_b;
      sb2_q     <= sb1_q;
      sa_prev_q <= sa2_q;
    end
  end

  assign sa_edge = sa2_q ^ sa_prev_q;
  assign pair_eq = (sa2_q == sb2_q);

  // Measurement FSM next-state and datapath: first edge arms, later edges report.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    count_d       = count_q;
    half_period_d = half_period_q;
    level_d       = level_q;
    meas_valid_d  = 1'b0;
    timeout_d     = timeout_q;

    case (state_q)
      ST_IDLE: begin
        // The partial half-period before the first edge is discarded.
        if (sa_edge) begin
          count_d   = CNT_W'(1);
          timeout_d = 1'b0;
          state_d   = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // An edge on the same cycle the count hits the limit still reports.
        if (sa_edge) begin
          half_period_d = count_q;
          level_d       = sa_prev_q;
          meas_valid_d  = 1'b1;
          count_d       = CNT_W'(1);
        end else if (count_q == TIMEOUT_C) begin
          timeout_d = 1'b1;
          count_d   = '0;
          state_d   = ST_IDLE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Complement checker: count consecutive equal cycles, error on the one past GLITCH.
  always_comb begin
    mis_cnt_d  = '0;
    comp_err_d = comp_err_q;
    if (pair_eq) begin
      mis_cnt_d = (mis_cnt_q == GLITCH_C) ? mis_cnt_q : mis_cnt_q + 1'b1;
      if (mis_cnt_q == GLITCH_C) begin
        comp_err_d = 1'b1;
      end
    end
  end

  // State and output registers for the FSM and the complement checker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      half_period_q <= '0;
      level_q       <= 1'b0;
      meas_valid_q  <= 1'b0;
      timeout_q     <= 1'b0;
      mis_cnt_q     <= '0;
      comp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      half_period_q <= half_period_d;
      level_q       <= level_d;
      meas_valid_q  <= meas_valid_d;
      timeout_q     <= timeout_d;
      mis_cnt_q     <= mis_cnt_d;
      comp_err_q    <= comp_err_d;
    end
  end

  assign mon_if.half_period = half_period_q;
  assign mon_if.level       = level_q;
  assign mon_if.meas_valid  = meas_valid_q;
  assign mon_if.timeout     = timeout_q;
  assign mon_if.comp_err    = comp_err_q;

endmodule

// File: tb/tb_siren_phase_meter.sv
// Directed scoreboard bench for siren_phase_meter: stimulus pushes the
// expected measurement for each completed half-period, a negedge monitor
// pops and compares on every meas_valid.
module tb_siren_phase_meter;

  localparam int CNT_W   = 27;
  localparam int TIMEOUT = 100;
  localparam int GLITCH  = 4;

  typedef struct packed {
    logic [CNT_W-1:0] hp;
    logic             lvl;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  siren_phase_meter_if #(.CNT_W(CNT_W)) mon_if ();

  siren_phase_meter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT),
    .GLITCH (GLITCH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon_if(mon_if)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Bench model of the half-period currently being timed.
  bit   meas_open = 1'b0;
  int   open_n    = 0;
  logic open_lvl  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Wait n rising edges, ending 1 time unit after the last one.
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
    if (meas_open) begin
      open_n += n;
      if (open_n > TIMEOUT) meas_open = 1'b0;
    end
  endtask

  // Toggle sig_a to lvl (sig_b to b); close the open half-period into the queue.
  task automatic start_half(input logic lvl, input logic b);
    exp_t e;
    mon_if.sig_a = lvl;
    mon_if.sig_b = b;
    if (meas_open) begin
      e.hp  = CNT_W'(open_n);
      e.lvl = open_lvl;
      exp_q.push_back(e);
    end
    meas_open = 1'b1;
    open_n    = 0;
    open_lvl  = lvl;
  endtask

  task automatic drive_half(input logic lvl, input int n);
    start_half(lvl, ~lvl);
    hold(n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_half_period"}, 32'(mon_if.half_period), 0);
    check({tag, "_level"},       32'(mon_if.level),       0);
    check({tag, "_meas_valid"},  32'(mon_if.meas_valid),  0);
    check({tag, "_timeout"},     32'(mon_if.timeout),     0);
    check({tag, "_comp_err"},    32'(mon_if.comp_err),    0);
  endtask

  // Monitor: every strobe must match the oldest expected measurement.
  always @(negedge clk) begin
    if (rst_n && mon_if.meas_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(mon_if.half_period), 0);
        if (mon_if.half_period == '0) begin
          errors++;
          $display("FAIL unexpected_valid: got strobe expected none (t=%0t)", $time);
        end
      end else begin
        mon_e = exp_q.pop_front();
        check("half_period", 32'(mon_if.half_period), 32'(mon_e.hp));
        check("level",       32'(mon_if.level),       32'(mon_e.lvl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    mon_if.sig_a = 1'b0;
    mon_if.sig_b = 1'b1;
    rst_n = 1'b0;

    // Reset with random inputs: outputs stay 0.
    repeat (6) begin
      @(posedge clk);
      #1;
      mon_if.sig_a = 1'($urandom_range(0, 1));
      mon_if.sig_b = 1'($urandom_range(0, 1));
    end
    check_all_zero("reset");
    mon_if.sig_a = 1'b0;
    mon_if.sig_b = 1'b1;
    hold(3);
    rst_n = 1'b1;
    hold(3);

    // Steady pair, 10-cycle halves: first report only after the second edge.
    for (int i = 0; i < 6; i++) drive_half((i % 2) == 0, 10);
    check("steady_timeout",  32'(mon_if.timeout),  0);
    check("steady_comp_err", 32'(mon_if.comp_err), 0);

    // Asymmetric duty: high 7, low 13.
    for (int i = 0; i < 3; i++) begin
      drive_half(1'b1, 7);
      drive_half(1'b0, 13);
    end

    // Short halves, then a half of exactly TIMEOUT (edge wins over timeout).
    drive_half(1'b1, 2);
    drive_half(1'b0, 2);
    drive_half(1'b1, TIMEOUT);
    drive_half(1'b0, 5);
    check("edge_wins_timeout", 32'(mon_if.timeout), 0);

    // Stall: timeout exactly TIMEOUT cycles after the edge takes effect.
    start_half(1'b1, 1'b0);
    hold(TIMEOUT + 2);
    check("stall_before_timeout", 32'(mon_if.timeout), 0);
    hold(1);
    check("stall_timeout", 32'(mon_if.timeout), 1);
    hold(20);
    check("stall_timeout_sticky", 32'(mon_if.timeout), 1);

    // Resume: timeout clears the cycle after the synced edge.
    start_half(1'b0, 1'b1);
    hold(2);
    check("resume_timeout_held", 32'(mon_if.timeout), 1);
    hold(1);
    check("resume_timeout_clear", 32'(mon_if.timeout), 0);
    hold(7);
    drive_half(1'b1, 10);
    drive_half(1'b0, 10);

    // Complement fault of GLITCH cycles: tolerated.
    start_half(1'b1, 1'b1);
    hold(GLITCH);
    mon_if.sig_b = 1'b0;
    hold(10 - GLITCH);
    check("glitch_tolerated", 32'(mon_if.comp_err), 0);

    // Complement fault of GLITCH+2 cycles: error on the (GLITCH+1)th equal cycle.
    start_half(1'b0, 1'b0);
    hold(GLITCH + 2);
    check("glitch_pre_err", 32'(mon_if.comp_err), 0);
    mon_if.sig_b = 1'b1;
    hold(1);
    check("glitch_err", 32'(mon_if.comp_err), 1);
    hold(3);
    drive_half(1'b1, 10);
    check("glitch_err_sticky", 32'(mon_if.comp_err), 1);

    // Async reset 5 cycles into a 10-cycle half: outputs clear before any edge.
    start_half(1'b0, 1'b1);
    hold(5);
    check("pre_reset_half_period", 32'(mon_if.half_period), 10);
    rst_n = 1'b0;
    meas_open = 1'b0;
    #1;
    check_all_zero("async_reset");
    hold(3);
    rst_n = 1'b1;
    hold(3);
    check("post_reset_half_period", 32'(mon_if.half_period), 0);
    drive_half(1'b1, 10);
    drive_half(1'b0, 10);
    drive_half(1'b1, 4);
    hold(5);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/siren_phase_meter.md
# siren_phase_meter

Receive-side monitor for the complementary slow square-wave pair produced by the team's siren/clock-divider block. Synchronizes both inputs into the `clk` domain and measures every half-period of `sig_a` in `clk` cycles. Reports each measurement with a one-cycle valid strobe, flags loss of toggling (timeout), and flags the pair failing to stay complementary. Sits on the board-level self-check path, feeding the LED/seven-segment debug logic.

## Interface
- `CNT_W`, 27: width of the half-period counter and of `half_period`.
- `TIMEOUT`, 125000000: cycles without a `sig_a` edge before `timeout` asserts; must be ≤ 2^CNT_W − 1.
- `GLITCH`, 4: consecutive cycles of synced `sig_a == sig_b` tolerated before `comp_err` sets.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sig_a` in 1: asynchronous input, nominal divided clock.
- `sig_b` in 1: asynchronous input, nominal complement of `sig_a`.
- `half_period` out CNT_W: length in `clk` cycles of the last completed half-period.
- `level` out 1: synced `sig_a` level during the half-period in `half_period`.
- `meas_valid` out 1: one-cycle strobe; `half_period`/`level` updated this cycle.
- `timeout` out 1: no `sig_a` edge for `TIMEOUT` cycles; sticky until next edge.
- `comp_err` out 1: complement violation seen; sticky until reset.

## Operation
- Reset (async, `rst_n` low): `sa1`, `sa2`, `sa_prev` = 0; `sb1`, `sb2` = 1; `count` = 0; `mis_cnt` = 0; state = IDLE. All outputs 0.
- Synchronizers: 2-flop chains, `sig_a`→`sa1`→`sa2`, `sig_b`→`sb1`→`sb2`. Only `sa2`/`sb2` are used downstream.
- Edge: `edge = sa2 ^ sa_prev`; `sa_prev <= sa2` every cycle.
- FSM, two states:
  - IDLE: no measurement in progress. On `edge`: `count <= 1`, `timeout <= 0`, go to MEASURE. No `meas_valid`; the first partial half-period is discarded.
  - MEASURE, on `edge`: `half_period <= count`, `level <= sa_prev`, `meas_valid <= 1`, `count <= 1`; stay in MEASURE.
  - MEASURE, no edge and `count == TIMEOUT`: `timeout <= 1`, `count <= 0`, go to IDLE.
  - MEASURE otherwise: `count <= count + 1`.
- Count rule: a synced level held for exactly N cycles yields `half_period = N`. `count` never exceeds `TIMEOUT`, so it cannot wrap.
- `meas_valid` is 0 in every cycle not listed above. `half_period`/`level` hold their value between strobes.
- Complement check:
  - If `sa2 == sb2`: `mis_cnt <= mis_cnt + 1`, saturating at `GLITCH`. Otherwise `mis_cnt <= 0`.
  - `comp_err <= 1` on the cycle `mis_cnt == GLITCH` and `sa2 == sb2`, i.e. the (GLITCH+1)th consecutive equal cycle.
  - Independent of the FSM; also runs in IDLE.
- Simultaneous events:
  - Edge on the cycle `count == TIMEOUT`: the edge wins; measurement reported, no timeout.
  - Timeout and complement error may assert in the same cycle.
- Reset mid-measurement: all state cleared immediately; the partial measurement is lost; next valid needs two edges after release.

## Timing
- Input transition to `edge` asserted: 2 cycles (synchronizer). `meas_valid` is registered, so it is high in the 3rd cycle after the input toggle is sampled.
- `meas_valid` width: exactly 1 cycle; minimum spacing equals the measured half-period (≥ 1 cycle).
- `timeout` asserts `TIMEOUT` cycles after the last edge. It clears in the cycle after the next detected edge.
- `comp_err` asserts GLITCH+1 cycles after the synced pair first becomes equal.
- Inputs toggling faster than 2 `clk` cycles are not guaranteed to be measured.

## Test plan
- Reset values: hold `rst_n` = 0 with random inputs → all outputs 0. Release → no `meas_valid` until two `sig_a` edges are seen.
- Steady pair, bench `TIMEOUT` = 100: `sig_a` toggles every 10 cycles, `sig_b = ~sig_a` → first strobe after the 2nd synced edge; every strobe reports `half_period` = 10 with `level` alternating; `comp_err`, `timeout` stay 0.
- Asymmetric duty: high 7, low 13 cycles → strobes alternate `half_period` 7/`level` 1 and 13/`level` 0.
- Stall: stop toggling `sig_a`, `TIMEOUT` = 100 → `timeout` = 1 exactly 100 cycles after the last edge. Resume toggling → `timeout` clears on the first edge; first new `meas_valid` only after the second edge.
- Complement fault, `GLITCH` = 4: force `sig_b = sig_a` for 4 cycles → no error. Force for 6 cycles → `comp_err` = 1 and stays 1 after recovery, until `rst_n` pulses.
- Async reset mid-measurement: assert `rst_n` low 5 cycles into a 10-cycle half-period → outputs 0 immediately, without waiting for a clock edge. After release, no stale `half_period` is reported.
